// File: rtl/dmem_responder.sv
// Data-memory responder: a word-organised RAM behind the dmem_* request/ack bus,
// with programmable response latency and error/misalignment status.
package biu_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;
endpackage

module dmem_responder
    import biu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 1024,
    parameter logic [XLEN-1:0] MEM_BASE = '0,
    parameter int              LATENCY  = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  biu_size_t       dmem_size,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault,
    input  logic            wait_inject,
    output logic            busy,
    output logic            proto_viol
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH * 4);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] wdat_q, wdat_d;
    logic            we_q, we_d;
    biu_size_t       size_q, size_d;
    logic [XLEN-1:0] q_q, q_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            mis_q, mis_d;
    logic            busy_q, busy_d;
    logic            pviol_q, pviol_d;

    logic            enter_resp;
    logic            acc_err;
    logic            acc_mis;
    logic            ram_we;
    logic [XLEN-1:0] off;
    logic [AW-1:0]   idx;
    logic [3:0]      be;

    logic [XLEN-1:0] ram [DEPTH];

    // Next-state logic. The *_d transaction fields hold the live bus values on an
    // accept edge and the captured ones otherwise, so commit logic sees one source.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        size_d  = size_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (dmem_req) begin
                    adr_d   = dmem_adr;
                    wdat_d  = dmem_d;
                    we_d    = dmem_we;
                    size_d  = dmem_size;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!wait_inject) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/commit logic: everything is evaluated for the edge that enters RESP.
    always_comb begin
        enter_resp = (state_d == ST_RESP);
        off        = adr_d - MEM_BASE;
        idx        = off[AW+1:2];
        acc_err    = (off >= SPAN) || !(size_d inside {BYTE, HWORD, WORD});
        acc_mis    = ((size_d == HWORD) && adr_d[0]) ||
                     ((size_d == WORD) && (adr_d[1:0] != 2'b00));
        case (size_d)
            BYTE:    be = 4'b0001 << adr_d[1:0];
            HWORD:   be = 4'b0011 << adr_d[1:0];
            default: be = 4'b1111;
        endcase
        ack_d   = enter_resp;
        err_d   = enter_resp && acc_err;
        mis_d   = enter_resp && !acc_err && acc_mis;
        // Gated by rstn so a request presented during reset never reaches the RAM.
        ram_we  = rstn && enter_resp && we_d && !acc_err && !acc_mis;
        q_d     = (enter_resp && !we_d && !acc_err && !acc_mis) ? ram[idx] : q_q;
        busy_d  = (state_d != ST_IDLE);
        pviol_d = pviol_q || (dmem_req && (state_q == ST_WAIT));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= BYTE;
            q_q     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            busy_q  <= 1'b0;
            pviol_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            size_q  <= size_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            pviol_q <= pviol_d;
        end
    end

    // NOTE: the RAM array has no reset; its contents survive rstn like real SRAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && be[i]) ram[idx][8*i +: 8] <= wdat_d[8*i +: 8];
        end
    end

    assign dmem_q          = q_q;
    assign dmem_ack        = ack_q;
    assign dmem_err        = err_q;
    assign dmem_misaligned = mis_q;
    assign dmem_page_fault = 1'b0;
    assign busy            = busy_q;
    assign proto_viol      = pviol_q;

endmodule
